mem_wait_bridge: RTL and testbench

//  Sits between the multicycle core's data/instruction memory port and a variable-latency memory.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/bus_timeout_counter.sv | 22 ++
 rtl/mem_wait_bridge.sv | 107 ++++++++++
 tb/tb_mem_wait_bridge.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared bus definitions for the core-to-memory wait-state bridge.
package riscv_pkg;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } bus_state_e;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction
endpackage

// File: rtl/bus_timeout_counter.sv
// Counts active bus cycles; hit marks the LIMIT-th cycle of an access.
module bus_timeout_counter #(
  parameter int LIMIT = 255,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // cnt holds the number of completed active cycles, so LIMIT-1 means this is the last one
  assign hit = en && (cnt == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/mem_wait_bridge.sv
// Turns the core's single-cycle memory access into a valid/ready request
// with a read-response handshake, stalling the core while it is in flight.
module mem_wait_bridge import riscv_pkg::*; #(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              core_done,
  output logic              bus_err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  bus_state_e state;
  logic aligned, start, active, tmo;

  assign aligned    = !ALIGN_CHECK || is_aligned(core_addr[1:0]);
  assign start      = (state == IDLE) && core_req && aligned;
  assign active     = (state == REQ) || (state == RESP);
  assign core_stall = active || start;

  bus_timeout_counter #(.LIMIT(TIMEOUT), .CNT_W(16)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (active),
    .hit   (tmo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      core_rdata <= '0;
      core_done  <= 1'b0;
      bus_err    <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      core_done <= 1'b0;
      case (state)
        IDLE: if (core_req) begin
          if (aligned) begin
            mem_valid <= 1'b1;
            mem_we    <= core_we;
            mem_addr  <= core_addr;
            mem_wdata <= core_wdata;
            state     <= REQ;
          end else begin
            bus_err   <= 1'b1;
            core_done <= 1'b1;
            state     <= DONE;
          end
        end
        REQ: begin
          // completion is tested before the timeout so a last-cycle finish is clean
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (mem_we || mem_rvalid) begin
              if (!mem_we) core_rdata <= mem_rdata;
              core_done <= 1'b1;
              state     <= DONE;
            end else if (tmo) begin
              bus_err   <= 1'b1;
              core_done <= 1'b1;
              state     <= DONE;
            end else begin
              state <= RESP;
            end
          end else if (tmo) begin
            mem_valid <= 1'b0;
            bus_err   <= 1'b1;
            core_done <= 1'b1;
            state     <= DONE;
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            core_rdata <= mem_rdata;
            core_done  <= 1'b1;
            state      <= DONE;
          end else if (tmo) begin
            bus_err   <= 1'b1;
            core_done <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_wait_bridge.sv
// Scoreboard bench: per-access expectations from a latency model, checked on each done pulse.
module tb_mem_wait_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic [DW-1:0] core_rdata;
  logic core_stall, core_done, bus_err, mem_valid, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_wait_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall), .core_done(core_done), .bus_err(bus_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rdata;
    int            done_cyc;
    int            stall_n;
    int            mv_n;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int checks = 0, errors = 0;
  logic m_err = 1'b0;
  logic [DW-1:0] m_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: accumulates per-access observations, compares on each done pulse
  int stall_n = 0, mv_n = 0;
  bit bad_mem = 0;
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      stall_n = 0; mv_n = 0; bad_mem = 0;
    end else begin
      stall_n += int'(core_stall);
      mv_n    += int'(mem_valid);
      if (mem_valid && q.size() > 0 &&
          (mem_addr !== q[0].addr || mem_we !== q[0].we || mem_wdata !== q[0].wdata))
        bad_mem = 1;
      if (core_done) begin
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          cur = q.pop_front();
          chk("done_cycle", cyc, cur.done_cyc);
          chk("bus_err", bus_err, cur.err);
          chk("core_rdata", core_rdata, cur.rdata);
          chk("stall_cycles", stall_n, cur.stall_n);
          chk("mem_valid_cycles", mv_n, cur.mv_n);
          chk("mem_fields_stable", bad_mem, 0);
        end
        stall_n = 0; mv_n = 0; bad_mem = 0;
      end
    end
  end

  // r: REQ cycles before mem_ready; v: cycles from handshake to mem_rvalid
  task automatic access(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int r, input int v, input logic [DW-1:0] rdata, input bit noise);
    exp_t e;
    int l, act, tot;
    bit al = (addr[1:0] == 2'b00);
    l   = we ? r + 1 : r + 1 + v;
    act = !al ? 0 : (l <= T ? l : T);
    if (!al || l > T) m_err = 1'b1;
    else if (!we) m_rdata = rdata;
    e.we = we; e.addr = addr; e.wdata = wdata;
    e.err = m_err; e.rdata = m_rdata;
    e.stall_n = al ? act + 1 : 0;
    e.mv_n    = al ? ((r + 1 < T) ? r + 1 : T) : 0;
    tot = al ? ((l > act + 1) ? l : act + 1) : 1;
    @(negedge clk);
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    e.done_cyc = cyc + 1 + act;
    q.push_back(e);
    for (int i = 1; i <= tot; i++) begin
      @(negedge clk);
      core_req = noise && i <= act && $urandom_range(1) == 1;
      if (noise) begin
        core_we = 1'($urandom); core_addr = $urandom; core_wdata = $urandom;
      end
      mem_ready  = al && i == r + 1;
      mem_rvalid = al && !we && (i == r + 1 + v || (noise && i <= r && $urandom_range(1) == 1));
      mem_rdata  = (al && !we && i == r + 1 + v) ? rdata : $urandom;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdata", core_rdata, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_done", core_done, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_stall", core_stall, 0);
    #1 reset = 1'b1;

    access(1'b0, 32'h10, 32'h0,        0, 0, 32'hCAFEF00D, 1'b0);
    access(1'b1, 32'h20, 32'h12345678, 3, 0, 32'h0,        1'b0);
    access(1'b0, 32'h30, 32'h0,        0, 5, 32'hA5A5A5A5, 1'b0);
    access(1'b0, 32'h2C, 32'h0,        2, 5, 32'h11112222, 1'b0);
    access(1'b1, 32'h22, 32'hDEAD,     0, 0, 32'h0,        1'b0);
    access(1'b0, 32'h40, 32'h0,       20, 1, 32'h0BADBEEF, 1'b0);
    access(1'b1, 32'h44, 32'h55,       0, 0, 32'h0,        1'b0);
    access(1'b0, 32'h48, 32'h0,        2, 6, 32'h33333333, 1'b0);

    // reset in the middle of a split read
    @(negedge clk); core_req = 1'b1; core_we = 1'b0; core_addr = 32'h54; mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk); core_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    #2 chk("resp_stall_pre", core_stall, 1);
    reset = 1'b0;
    #1;
    chk("rst_resp_stall", core_stall, 0);
    chk("rst_resp_err", bus_err, 0);
    chk("rst_resp_rdata", core_rdata, 0);
    chk("rst_resp_done", core_done, 0);
    chk("rst_resp_mem_addr", mem_addr, 0);
    @(negedge clk); #2 reset = 1'b1;
    m_err = 1'b0; m_rdata = '0;

    // reset while the request is still presented
    @(negedge clk); core_req = 1'b1; core_addr = 32'h60;
    @(negedge clk); core_req = 1'b0;
    #2 chk("req_valid_pre", mem_valid, 1);
    reset = 1'b0;
    #1 chk("rst_req_mem_valid", mem_valid, 0);
    @(negedge clk); #2 reset = 1'b1;

    access(1'b0, 32'h58, 32'h0, 1, 2, 32'h5A5AC3C3, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      if (n % 5 == 0) begin
        @(negedge clk); core_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        m_err = 1'b0; m_rdata = '0;
      end
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      access(1'($urandom), a, $urandom, $urandom_range(0, 6), $urandom_range(0, 6), $urandom, 1'b1);
    end

    @(negedge clk); core_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
